// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver. The serial line is brought into the clk domain through a
// two-flop synchroniser, and each bit is sampled at its nominal mid-point by a
// small FSM. A byte is delivered to the consumer through a one-deep holding
// register with a valid/ready handshake. Framing and overrun errors are
// reported as sticky flags that clear on the next handshake.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (must be >= 4)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   rxd        serial input, idles high, asynchronous to clk
//   rx_data    last accepted byte, stable while rx_valid is high
//   rx_valid   rx_data holds a byte that has not been consumed yet
//   rx_ready   consumer takes the byte when rx_valid && rx_ready at a posedge
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte was dropped because the holding register was full
//   busy       high whenever the receive FSM is not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Start bit is checked half a bit in, so every later sample lands mid-bit.
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Registered state
    logic [1:0]       sync_q,      sync_d;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       idx_q,       idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             busy_q,      busy_d;

    // Combinational helpers
    logic rxd_s;
    logic handshake;
    logic deliver;
    logic frame_set;

    assign rxd_s = sync_q[1];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sync_d      = {sync_q[0], rxd};
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        handshake   = rx_valid_q && rx_ready;
        deliver     = 1'b0;
        frame_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so after eight shifts it sits in bit 0.
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Wait for the line to recover so a held-low line cannot
                // be mistaken for a stream of start bits.
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Consumer handshake empties the holding register and clears errors.
        if (handshake) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        // A byte may load into a register being emptied this same cycle.
        if (deliver) begin
            if (!rx_valid_q || handshake) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Applied after the handshake clear so a new error is never lost.
        if (frame_set) begin
            frame_err_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // pre-edge values, so ordering inside this block does not matter.
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16. Every byte expected
// to reach the consumer is pushed to exp_q when its frame is driven; a monitor
// pops and compares on each handshake. Scenario tasks also check flags and
// data directly.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_checks = 0;
    int         n_pass = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Scoreboard: a handshake happens at the posedge following a negedge
    // where rx_valid and rx_ready are both high.
    always @(negedge clk) begin
        if (!reset && rx_valid) begin
            valid_cycles++;
        end
        if (!reset && rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got byte %h, none expected", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    $display("FAIL sb_data: got %h want %h", rx_data, exp_b);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop);
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rx_valid) ok = 1'b1;
        end
    endtask

    task automatic pulse_ready;
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rst_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_ferr: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rst_ovr: got %b want 0", overrun); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        send_bit(1'b1);
    endtask

    task automatic test_basic;
        logic ok;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_valid(4, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL t1_timeout: rx_valid %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'hA5) $display("FAIL t1_data: got %h want a5", rx_data); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t1_ferr: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL t1_ovr: got %b want 0", overrun); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t1_busy: got %b want 0", busy); else n_pass++;
        pulse_ready();
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t1_consume: rx_valid %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_glitch;
        logic ok;
        logic saw_busy;
        logic saw_valid;
        saw_busy = 1'b0;
        saw_valid = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) rxd = 1'b1;
            if (busy) saw_busy = 1'b1;
            if (rx_valid) saw_valid = 1'b1;
        end
        n_checks++; if (saw_busy !== 1'b1) $display("FAIL t2_busy_pulse: saw %b want 1", saw_busy); else n_pass++;
        n_checks++; if (saw_valid !== 1'b0) $display("FAIL t2_no_valid: saw %b want 0", saw_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t2_busy_end: got %b want 0", busy); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t2_ferr: got %b want 0", frame_err); else n_pass++;
        send_bit(1'b1);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_valid(4, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL t2_timeout: rx_valid %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h3C) $display("FAIL t2_data: got %h want 3c", rx_data); else n_pass++;
        pulse_ready();
    endtask

    task automatic test_frame_err;
        logic ok;
        logic [7:0] d;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        // Stop bit low, line held low for three bit times in total.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        n_checks++; if (frame_err !== 1'b1) $display("FAIL t3_ferr_set: got %b want 1", frame_err); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t3_no_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL t3_busy_break: got %b want 1", busy); else n_pass++;
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL t3_busy_release: got %b want 0", busy); else n_pass++;
        send_bit(1'b1);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_valid(4, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL t3_timeout: rx_valid %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h11) $display("FAIL t3_data: got %h want 11", rx_data); else n_pass++;
        n_checks++; if (frame_err !== 1'b1) $display("FAIL t3_ferr_sticky: got %b want 1", frame_err); else n_pass++;
        pulse_ready();
        @(negedge clk);
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t3_ferr_clear: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t3_consume: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL t4_valid: got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h01) $display("FAIL t4_data: got %h want 01", rx_data); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL t4_ovr_set: got %b want 1", overrun); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t4_ferr: got %b want 0", frame_err); else n_pass++;
        pulse_ready();
        @(negedge clk);
        n_checks++; if (overrun !== 1'b0) $display("FAIL t4_ovr_clear: got %b want 0", overrun); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t4_consume: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        send_bit(1'b1);
        valid_cycles = 0;
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1);
        rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (valid_cycles !== 2) $display("FAIL t5_pulses: got %0d valid cycles want 2", valid_cycles); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL t5_drain: %0d bytes undelivered want 0", exp_q.size()); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t5_ferr: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL t5_ovr: got %b want 0", overrun); else n_pass++;
        n_checks++; if (rx_data !== 8'hFF) $display("FAIL t5_last: got %h want ff", rx_data); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic ok;
        logic [7:0] d;
        d = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(d[i]);
        end
        rxd = d[4];
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL t6_busy_mid: got %b want 1", busy); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL t6_rst_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t6_rst_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t6_rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL t6_rst_ferr: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL t6_rst_ovr: got %b want 0", overrun); else n_pass++;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        send_bit(1'b1);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL t6_no_partial: got %b want 0", rx_valid); else n_pass++;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        wait_valid(4, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL t6_timeout: rx_valid %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h42) $display("FAIL t6_data: got %h want 42", rx_data); else n_pass++;
        pulse_ready();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        n_checks++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: %0d bytes never delivered", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
